// File: rtl/clock_ratio_monitor.sv
// Receive-side checker for a divided clock: samples it in the reference domain,
// measures high/low/period lengths and checks them against the programmed ratio.
module clock_ratio_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned LOCK_CNT    = 4
) (
    input  logic             I_ref_clk,
    input  logic             I_rst_n,
    input  logic             I_mon_en,
    input  logic [3:0]       I_div_ratio,
    input  logic             I_div_clk,
    output logic [CNT_W:0]   O_ratio,
    output logic [CNT_W-1:0] O_high_len,
    output logic             O_valid,
    output logic             O_err,
    output logic             O_locked,
    output logic             O_timeout,
    output logic             O_bypass
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam int unsigned      STRK_W   = $clog2(LOCK_CNT + 1);
    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [SYNC_STAGES:0]   prime_q, prime_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       high_q, high_d;
    state_t                 state_q, state_d;
    logic [CNT_W:0]         ratio_q, ratio_d;
    logic [CNT_W-1:0]       high_len_q, high_len_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;
    logic                   bypass_q, bypass_d;
    logic [STRK_W-1:0]      streak_q, streak_d;
    logic [3:0]             div_ratio_q, div_ratio_d;

    logic                   primed;
    logic                   sync_s;
    logic                   rise;
    logic                   fall;
    logic                   edge_det;
    logic                   cnt_sat;
    logic [CNT_W:0]         period;
    logic [CNT_W-1:0]       half;
    logic                   match;
    logic                   bypass_now;
    logic                   ratio_chg;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], I_div_clk};
        hist_d      = sync_q[SYNC_STAGES-1];
        prime_d     = {prime_q[SYNC_STAGES-1:0], 1'b1};
        sync_s      = sync_q[SYNC_STAGES-1];

        // Edges are qualified only once the history flop holds a genuinely
        // sampled value, so a clock already high at reset release is not
        // mistaken for a rise that would open a truncated period.
        primed      = prime_q[SYNC_STAGES];
        rise        = primed & sync_s & ~hist_q;
        fall        = primed & ~sync_s & hist_q;
        edge_det    = rise | fall;
        cnt_sat     = (cnt_q == CNT_MAX);

        if (edge_det) begin
            cnt_d = CNT_W'(1);
        end else if (!cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        period      = {1'b0, high_q} + {1'b0, cnt_q};
        half        = CNT_W'(I_div_ratio >> 1);
        match       = (period == (CNT_W+1)'(I_div_ratio)) &&
                      ((high_q == half) || (I_div_ratio[0] && (high_q == half + CNT_W'(1))));
        bypass_now  = (I_div_ratio < 4'd2);
        ratio_chg   = (I_div_ratio != div_ratio_q);

        state_d     = state_q;
        high_d      = high_q;
        ratio_d     = ratio_q;
        high_len_d  = high_len_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        streak_d    = streak_q;
        timeout_d   = timeout_q;
        bypass_d    = bypass_now;
        div_ratio_d = I_div_ratio;

        if (!I_mon_en) begin
            state_d   = IDLE;
            streak_d  = '0;
            timeout_d = 1'b0;
        end else if (bypass_now) begin
            state_d  = IDLE;
            streak_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_d  = cnt_q;
                        state_d = MEAS_LOW;
                    end else if (cnt_sat && !edge_det) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        streak_d  = '0;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        ratio_d    = period;
                        high_len_d = high_q;
                        valid_d    = 1'b1;
                        err_d      = ~match;
                        state_d    = MEAS_HIGH;
                        if (!match) begin
                            streak_d = '0;
                        end else if (streak_q != STRK_MAX) begin
                            streak_d = streak_q + STRK_W'(1);
                        end
                    end else if (cnt_sat && !edge_det) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        streak_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (ratio_chg) begin
                streak_d = '0;
            end
        end

        locked_d = (streak_d == STRK_MAX);
    end

    always_ff @(posedge I_ref_clk) begin
        if (!I_rst_n) begin
            sync_q      <= '0;
            hist_q      <= 1'b0;
            prime_q     <= '0;
            cnt_q       <= '0;
            high_q      <= '0;
            state_q     <= IDLE;
            ratio_q     <= '0;
            high_len_q  <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            bypass_q    <= 1'b0;
            streak_q    <= '0;
            div_ratio_q <= '0;
        end else begin
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            prime_q     <= prime_d;
            cnt_q       <= cnt_d;
            high_q      <= high_d;
            state_q     <= state_d;
            ratio_q     <= ratio_d;
            high_len_q  <= high_len_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
            bypass_q    <= bypass_d;
            streak_q    <= streak_d;
            div_ratio_q <= div_ratio_d;
        end
    end

    assign O_ratio    = ratio_q;
    assign O_high_len = high_len_q;
    assign O_valid    = valid_q;
    assign O_err      = err_q;
    assign O_locked   = locked_q;
    assign O_timeout  = timeout_q;
    assign O_bypass   = bypass_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed bench for clock_ratio_monitor: drives divided-clock waveforms and
// checks measured lengths, error pulses, lock, timeout and bypass behaviour.
module tb_clock_ratio_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mon_en;
    logic [3:0] div_ratio;
    logic       div_clk;
    logic [5:0] o_ratio;
    logic [4:0] o_high_len;
    logic       o_valid;
    logic       o_err;
    logic       o_locked;
    logic       o_timeout;
    logic       o_bypass;

    int checks = 0;
    int errors = 0;

    int tick_no = 0;
    int nv, ne, err_orphan, first_ratio, last_ratio, last_high, last_err, last_lock;
    int first_lock_idx, last_vtick, last_spacing;

    always #5 clk = ~clk;

    clock_ratio_monitor #(
        .SYNC_STAGES(2),
        .CNT_W(5),
        .LOCK_CNT(4)
    ) dut (
        .I_ref_clk  (clk),
        .I_rst_n    (rst_n),
        .I_mon_en   (mon_en),
        .I_div_ratio(div_ratio),
        .I_div_clk  (div_clk),
        .O_ratio    (o_ratio),
        .O_high_len (o_high_len),
        .O_valid    (o_valid),
        .O_err      (o_err),
        .O_locked   (o_locked),
        .O_timeout  (o_timeout),
        .O_bypass   (o_bypass)
    );

    task automatic clear_obs();
        nv = 0; ne = 0; err_orphan = 0; first_ratio = 0; last_ratio = 0;
        last_high = 0; last_err = 0; last_lock = 0; first_lock_idx = 0;
        last_vtick = 0; last_spacing = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        if (o_valid === 1'b1) begin
            nv++;
            if (nv == 1) first_ratio = int'(o_ratio);
            last_ratio = int'(o_ratio);
            last_high  = int'(o_high_len);
            last_err   = int'(o_err);
            last_lock  = int'(o_locked);
            if (o_locked === 1'b1 && first_lock_idx == 0) first_lock_idx = nv;
            if (last_vtick != 0) last_spacing = tick_no - last_vtick;
            last_vtick = tick_no;
        end
        if (o_err === 1'b1) ne++;
        if (o_err === 1'b1 && o_valid !== 1'b1) err_orphan++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_periods(input int n, input int h, input int l);
        for (int i = 0; i < n; i++) begin
            div_clk = 1'b1;
            for (int j = 0; j < h; j++) tick();
            div_clk = 1'b0;
            for (int j = 0; j < l; j++) tick();
        end
    endtask

    task automatic do_reset(input logic [3:0] ratio);
        div_ratio = ratio;
        div_clk   = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        clear_obs();
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_ratio, o_high_len, o_valid, o_err, o_locked, o_timeout, o_bypass});
    endfunction

    initial begin
        rst_n = 1'b0; mon_en = 1'b1; div_ratio = 4'd4; div_clk = 1'b0;
        clear_obs();

        // Ratio 4, 2H/2L: reset state, then four matching periods lock.
        tick(); tick();
        check("reset_outputs", all_outs(), 32'd0);
        do_reset(4'd4);
        run_periods(5, 2, 2);
        check("r4_valid_count", nv, 4);
        check("r4_ratio", last_ratio, 4);
        check("r4_high_len", last_high, 2);
        check("r4_err_count", ne, 0);
        check("r4_lock_at_4th", first_lock_idx, 4);
        check("r4_valid_spacing", last_spacing, 4);
        check("r4_locked_level", o_locked, 1);

        // Ratio 5, alternating 3H/2L and 2H/3L, then one bad 4H/1L period.
        do_reset(4'd5);
        for (int i = 0; i < 3; i++) begin
            run_periods(1, 3, 2);
            run_periods(1, 2, 3);
        end
        check("r5_valid_count", nv, 5);
        check("r5_err_count", ne, 0);
        check("r5_lock_at_4th", first_lock_idx, 4);
        run_periods(1, 4, 1);
        run_periods(1, 2, 3);
        check("r5_bad_valid_count", nv, 7);
        check("r5_bad_err", last_err, 1);
        check("r5_bad_lock_drop", last_lock, 0);
        check("r5_bad_high_len", last_high, 4);
        check("r5_bad_ratio", last_ratio, 5);
        check("r5_err_count", ne, 1);
        check("r5_err_without_valid", err_orphan, 0);

        // Ratio 6 locked, then clock stuck high -> timeout 31 cycles after the rise.
        do_reset(4'd6);
        run_periods(6, 3, 3);
        check("r6_locked_before_stuck", o_locked, 1);
        div_clk = 1'b1;
        for (int i = 0; i < 33; i++) tick();
        check("r6_timeout_not_yet", o_timeout, 0);
        check("r6_locked_still", o_locked, 1);
        tick();
        check("r6_timeout_set", o_timeout, 1);
        check("r6_locked_cleared", o_locked, 0);
        check("r6_valid_count", nv, 6);
        clear_obs();
        div_clk = 1'b0;
        tick(); tick(); tick();
        run_periods(4, 3, 3);
        check("r6_resume_valids", nv, 3);
        check("r6_resume_errs", ne, 0);
        check("r6_timeout_sticky", o_timeout, 1);
        check("r6_relock_pending", o_locked, 0);
        mon_en = 1'b0;
        tick(); tick();
        check("r6_timeout_cleared", o_timeout, 0);
        mon_en = 1'b1;

        // Bypass: ratio 1 and ratio 0 produce no measurements and no timeout.
        do_reset(4'd1);
        run_periods(5, 2, 2);
        check("byp1_flag", o_bypass, 1);
        check("byp1_no_valid", nv, 0);
        check("byp1_no_err", ne, 0);
        div_ratio = 4'd0;
        div_clk = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("byp0_flag", o_bypass, 1);
        check("byp0_no_timeout", o_timeout, 0);
        check("byp0_no_valid", nv, 0);
        check("byp0_no_lock", o_locked, 0);

        // Ratio 8: reset in the middle of a high phase discards the partial period.
        do_reset(4'd8);
        run_periods(2, 4, 4);
        div_clk = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("r8_reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        clear_obs();
        tick();
        div_clk = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        run_periods(3, 4, 4);
        check("r8_valid_count", nv, 2);
        check("r8_first_ratio", first_ratio, 8);
        check("r8_high_len", last_high, 4);
        check("r8_err_count", ne, 0);

        // Ratio 4 locked, ratio switched to 6 with the clock unchanged.
        do_reset(4'd4);
        run_periods(6, 2, 2);
        check("chg_locked_before", o_locked, 1);
        clear_obs();
        div_clk = 1'b1;
        div_ratio = 4'd6;
        tick();
        check("chg_lock_drop", o_locked, 0);
        tick();
        div_clk = 1'b0;
        tick(); tick();
        run_periods(4, 2, 2);
        check("chg_valid_count", nv, 5);
        check("chg_err_count", ne, 5);
        check("chg_ratio", last_ratio, 4);
        check("chg_lock_at_valid", last_lock, 0);
        check("chg_err_without_valid", err_orphan, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
